// File: rtl/e_mdu_if.sv
// Execute-stage multiply/divide bus: operation request from the pipeline,
// HI/LO state, read data and stall/busy status back from the unit.
interface e_mdu_if;
  logic        E_en;
  logic [3:0]  E_mdu_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_cancel;
  logic        E_busy;
  logic        E_mdu_stall;
  logic [31:0] E_mdu_out;
  logic [31:0] E_HI;
  logic [31:0] E_LO;

  modport master (
    output E_en, E_mdu_op, E_A, E_B, E_cancel,
    input  E_busy, E_mdu_stall, E_mdu_out, E_HI, E_LO
  );

  modport slave (
    input  E_en, E_mdu_op, E_A, E_B, E_cancel,
    output E_busy, E_mdu_stall, E_mdu_out, E_HI, E_LO
  );
endinterface

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit holding HI/LO. The full result is captured
// at the start edge and committed after MULT_CYCLES/DIV_CYCLES busy cycles.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  e_mdu_if.slave   mdu
);
  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] C_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo, r_hi_tmp, r_lo_tmp;

  logic             w_is_mdu, w_is_start, w_start, w_mthi, w_mtlo, w_b_zero;
  logic signed [63:0] w_smul;
  logic [63:0]      w_umul, w_res;

  // Returns {remainder, quotient}; the only overflowing case is pinned explicitly.
  function automatic logic [63:0] f_sdiv(input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, q, r;
    sa = a;
    sb = b;
    if (b == 32'd0)
      return 64'd0;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'd0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction

  function automatic logic [63:0] f_udiv(input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0)
      return 64'd0;
    return {a % b, a / b};
  endfunction

  assign w_is_mdu   = (mdu.E_mdu_op >= OP_MULT) && (mdu.E_mdu_op <= OP_MFLO);
  assign w_is_start = (mdu.E_mdu_op >= OP_MULT) && (mdu.E_mdu_op <= OP_DIVU);
  assign w_start    = mdu.E_en & w_is_start & ~r_busy & ~mdu.E_cancel;
  assign w_mthi     = mdu.E_en & (mdu.E_mdu_op == OP_MTHI) & ~r_busy & ~mdu.E_cancel;
  assign w_mtlo     = mdu.E_en & (mdu.E_mdu_op == OP_MTLO) & ~r_busy & ~mdu.E_cancel;
  assign w_b_zero   = (mdu.E_B == 32'd0);

  assign w_smul = $signed({{32{mdu.E_A[31]}}, mdu.E_A}) * $signed({{32{mdu.E_B[31]}}, mdu.E_B});
  assign w_umul = {32'd0, mdu.E_A} * {32'd0, mdu.E_B};

  // A zero divisor re-captures the committed HI/LO so the commit is a no-op.
  always_comb begin
    w_res = {r_hi, r_lo};
    case (mdu.E_mdu_op)
      OP_MULT:  w_res = w_smul;
      OP_MULTU: w_res = w_umul;
      OP_DIV:   if (!w_b_zero) w_res = f_sdiv(mdu.E_A, mdu.E_B);
      OP_DIVU:  if (!w_b_zero) w_res = f_udiv(mdu.E_A, mdu.E_B);
      default:  w_res = {r_hi, r_lo};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_hi_tmp <= '0;
      r_lo_tmp <= '0;
    end else if (r_busy) begin
      if (mdu.E_cancel) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else if (r_cnt == C_ONE) begin
        r_hi   <= r_hi_tmp;
        r_lo   <= r_lo_tmp;
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt - C_ONE;
      end
    end else if (w_start) begin
      r_hi_tmp <= w_res[63:32];
      r_lo_tmp <= w_res[31:0];
      r_busy   <= 1'b1;
      r_cnt    <= (mdu.E_mdu_op <= OP_MULTU) ? C_MULT : C_DIV;
    end else if (w_mthi) begin
      r_hi <= mdu.E_A;
    end else if (w_mtlo) begin
      r_lo <= mdu.E_A;
    end
  end

  always_comb begin
    mdu.E_mdu_out = 32'd0;
    if (mdu.E_mdu_op == OP_MFHI)
      mdu.E_mdu_out = r_hi;
    else if (mdu.E_mdu_op == OP_MFLO)
      mdu.E_mdu_out = r_lo;
  end

  assign mdu.E_busy      = r_busy;
  assign mdu.E_mdu_stall = mdu.E_en & w_is_mdu & r_busy;
  assign mdu.E_HI        = r_hi;
  assign mdu.E_LO        = r_lo;
endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops
// against an arithmetic reference model of HI/LO.
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  e_mdu_if bus();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .mdu(bus));

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] m_hi, m_lo;

  // Expected {HI, LO} after an op completes, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] hi,
                                             input logic [31:0] lo);
    int sa, sb;
    longint p, q, r;
    longint unsigned up;
    sa = a;
    sb = b;
    ref_result = {hi, lo};
    case (op)
      4'd1: begin p = longint'(sa) * longint'(sb); ref_result = p; end
      4'd2: begin up = {32'd0, a} * {32'd0, b}; ref_result = up; end
      4'd3: if (b != 0) begin
        q = longint'(sa) / longint'(sb);
        r = longint'(sa) - q * longint'(sb);
        ref_result = {r[31:0], q[31:0]};
      end
      4'd4: if (b != 0) ref_result = {a % b, a / b};
      default: ref_result = {hi, lo};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.E_en = 1'b0; bus.E_mdu_op = 4'd0; bus.E_A = '0; bus.E_B = '0; bus.E_cancel = 1'b0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.E_en = 1'b1; bus.E_mdu_op = op; bus.E_A = a; bus.E_B = b; bus.E_cancel = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (bus.E_busy === 1'b1 && cyc < 100) begin
      cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    #3;
    n_total++; if (bus.E_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.E_busy); else n_pass++;
    n_total++; if ({bus.E_HI, bus.E_LO} !== 64'd0) $display("FAIL reset_hilo: got %h want 0", {bus.E_HI, bus.E_LO}); else n_pass++;
    n_total++; if (bus.E_mdu_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.E_mdu_stall); else n_pass++;
    step();
    #2 reset = 1'b1;
    step();
    m_hi = 0; m_lo = 0;
  endtask

  task automatic test_mult();
    int cyc;
    drive(4'd1, 32'hFFFF_FFFF, 32'd2);
    #1;
    n_total++; if (bus.E_mdu_stall !== 1'b0) $display("FAIL start_stall: got %b want 0", bus.E_mdu_stall); else n_pass++;
    step(); idle();
    wait_idle(cyc);
    n_total++; if (cyc != MC) $display("FAIL mult_cycles: got %0d want %0d", cyc, MC); else n_pass++;
    n_total++; if ({bus.E_HI, bus.E_LO} !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL mult_hilo: got %h want ffffffff_fffffffe", {bus.E_HI, bus.E_LO}); else n_pass++;
    m_hi = bus.E_HI; m_lo = bus.E_LO;
  endtask

  task automatic test_multu_stall();
    int bad;
    drive(4'd6, 32'hA5A5_A5A5, 32'd0); step();
    m_lo = 32'hA5A5_A5A5;
    drive(4'd2, 32'hFFFF_FFFF, 32'd2); step();
    bad = 0;
    for (int i = 0; i < MC; i++) begin
      drive(4'd8, 32'd0, 32'd0);
      #1;
      if (bus.E_mdu_stall !== 1'b1 || bus.E_mdu_out !== m_lo || bus.E_busy !== 1'b1) bad++;
      step();
    end
    n_total++; if (bad != 0) $display("FAIL multu_stall_old_lo: got %0d bad cycles want 0", bad); else n_pass++;
    n_total++; if (bus.E_busy !== 1'b0 || bus.E_mdu_stall !== 1'b0)
      $display("FAIL multu_release: got busy=%b stall=%b want 0 0", bus.E_busy, bus.E_mdu_stall); else n_pass++;
    n_total++; if (bus.E_mdu_out !== 32'hFFFF_FFFE || bus.E_HI !== 32'h1)
      $display("FAIL multu_result: got out=%h hi=%h want fffffffe 00000001", bus.E_mdu_out, bus.E_HI); else n_pass++;
    idle();
    m_hi = 32'h1; m_lo = 32'hFFFF_FFFE;
  endtask

  task automatic test_div();
    int cyc;
    drive(4'd3, 32'hFFFF_FFF9, 32'd2); step(); idle();
    wait_idle(cyc);
    n_total++; if (cyc != DC) $display("FAIL div_cycles: got %0d want %0d", cyc, DC); else n_pass++;
    n_total++; if ({bus.E_HI, bus.E_LO} !== 64'hFFFF_FFFF_FFFF_FFFD)
      $display("FAIL div_hilo: got %h want ffffffff_fffffffd", {bus.E_HI, bus.E_LO}); else n_pass++;
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFD;
    drive(4'd4, 32'd7, 32'd0); step(); idle();
    wait_idle(cyc);
    n_total++; if (cyc != DC) $display("FAIL divu0_cycles: got %0d want %0d", cyc, DC); else n_pass++;
    n_total++; if ({bus.E_HI, bus.E_LO} !== {m_hi, m_lo})
      $display("FAIL divu0_hilo: got %h want %h", {bus.E_HI, bus.E_LO}, {m_hi, m_lo}); else n_pass++;
  endtask

  task automatic test_mthi_mtlo();
    drive(4'd5, 32'h1234_5678, 32'd0); step();
    n_total++; if (bus.E_busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", bus.E_busy); else n_pass++;
    drive(4'd6, 32'h9ABC_DEF0, 32'd0); step();
    drive(4'd7, 32'd0, 32'd0); #1;
    n_total++; if (bus.E_mdu_out !== 32'h1234_5678) $display("FAIL mfhi: got %h want 12345678", bus.E_mdu_out); else n_pass++;
    drive(4'd8, 32'd0, 32'd0); #1;
    n_total++; if (bus.E_mdu_out !== 32'h9ABC_DEF0) $display("FAIL mflo: got %h want 9abcdef0", bus.E_mdu_out); else n_pass++;
    step(); idle();
    m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
  endtask

  task automatic test_cancel();
    int cyc;
    drive(4'd1, 32'd3, 32'd4); step(); idle();
    step(); step();
    bus.E_cancel = 1'b1;
    step();
    bus.E_cancel = 1'b0;
    n_total++; if (bus.E_busy !== 1'b0) $display("FAIL cancel_busy: got %b want 0", bus.E_busy); else n_pass++;
    for (int i = 0; i < MC; i++) step();
    n_total++; if ({bus.E_HI, bus.E_LO} !== {m_hi, m_lo})
      $display("FAIL cancel_hilo: got %h want %h", {bus.E_HI, bus.E_LO}, {m_hi, m_lo}); else n_pass++;
    drive(4'd1, 32'd5, 32'd6); bus.E_cancel = 1'b1; step(); idle();
    n_total++; if (bus.E_busy !== 1'b0) $display("FAIL cancel_start: got %b want 0", bus.E_busy); else n_pass++;
    drive(4'd5, 32'hDEAD_BEEF, 32'd0); bus.E_cancel = 1'b1; step(); idle();
    n_total++; if (bus.E_HI !== m_hi) $display("FAIL cancel_mthi: got %h want %h", bus.E_HI, m_hi); else n_pass++;
    drive(4'd1, 32'd3, 32'd4); step(); idle();
    wait_idle(cyc);
    n_total++; if ({bus.E_HI, bus.E_LO} !== 64'd12)
      $display("FAIL mult_after_cancel: got %h want 0000000c", {bus.E_HI, bus.E_LO}); else n_pass++;
    m_hi = 0; m_lo = 32'd12;
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [63:0] exp;
    drive(4'd3, 32'd1000, 32'd7); step();
    exp = ref_result(4'd3, 32'd1000, 32'd7, m_hi, m_lo);
    drive(4'd1, 32'd9, 32'd9); step();
    drive(4'd5, 32'hCAFE_0000, 32'd0); step();
    idle();
    wait_idle(cyc);
    n_total++; if (cyc != DC - 2) $display("FAIL b2b_cycles: got %0d want %0d", cyc, DC - 2); else n_pass++;
    n_total++; if ({bus.E_HI, bus.E_LO} !== exp)
      $display("FAIL b2b_hilo: got %h want %h", {bus.E_HI, bus.E_LO}, exp); else n_pass++;
    m_hi = exp[63:32]; m_lo = exp[31:0];
    drive(4'd2, 32'd2, 32'd3); step(); idle();
    n_total++; if (bus.E_busy !== 1'b1) $display("FAIL b2b_restart: got %b want 1", bus.E_busy); else n_pass++;
    wait_idle(cyc);
    m_hi = 0; m_lo = 32'd6;
  endtask

  task automatic test_async_reset();
    int cyc;
    drive(4'd3, 32'd100, 32'd7); step(); idle();
    step(); step();
    #2 reset = 1'b0;
    #1;
    n_total++; if (bus.E_busy !== 1'b0 || bus.E_HI !== 32'd0 || bus.E_LO !== 32'd0)
      $display("FAIL async_reset: got busy=%b hi=%h lo=%h want 0 0 0", bus.E_busy, bus.E_HI, bus.E_LO); else n_pass++;
    #2 reset = 1'b1;
    for (int i = 0; i < DC + 3; i++) step();
    n_total++; if ({bus.E_HI, bus.E_LO} !== 64'd0 || bus.E_busy !== 1'b0)
      $display("FAIL reset_no_commit: got %h busy=%b want 0", {bus.E_HI, bus.E_LO}, bus.E_busy); else n_pass++;
    drive(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); step(); idle();
    wait_idle(cyc);
    n_total++; if ({bus.E_HI, bus.E_LO} !== 64'h0000_0000_8000_0000)
      $display("FAIL div_overflow: got %h want 00000000_80000000", {bus.E_HI, bus.E_LO}); else n_pass++;
    m_hi = 0; m_lo = 32'h8000_0000;
  endtask

  task automatic test_random();
    int cyc, sel;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 60; i++) begin
      op  = 4'($urandom_range(0, 15));
      sel = $urandom_range(0, 7);
      a   = (sel == 2) ? 32'h8000_0000 : $urandom;
      b   = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF : $urandom;
      drive(op, a, b);
      #1;
      if (op == 4'd7 || op == 4'd8) begin
        n_total++; if (bus.E_mdu_out !== ((op == 4'd7) ? m_hi : m_lo))
          $display("FAIL rnd_mf op=%0d: got %h want %h", op, bus.E_mdu_out, (op == 4'd7) ? m_hi : m_lo); else n_pass++;
      end else if (op == 4'd0 || op > 4'd8) begin
        n_total++; if (bus.E_mdu_out !== 32'd0) $display("FAIL rnd_out_zero op=%0d: got %h want 0", op, bus.E_mdu_out); else n_pass++;
      end
      step(); idle();
      if (op >= 4'd1 && op <= 4'd4) begin
        exp = ref_result(op, a, b, m_hi, m_lo);
        wait_idle(cyc);
        n_total++; if (cyc != ((op <= 4'd2) ? MC : DC))
          $display("FAIL rnd_cycles op=%0d: got %0d want %0d", op, cyc, (op <= 4'd2) ? MC : DC); else n_pass++;
        m_hi = exp[63:32]; m_lo = exp[31:0];
      end else if (op == 4'd5) begin
        m_hi = a;
      end else if (op == 4'd6) begin
        m_lo = a;
      end
      n_total++; if ({bus.E_HI, bus.E_LO} !== {m_hi, m_lo} || bus.E_busy !== 1'b0)
        $display("FAIL rnd_state op=%0d a=%h b=%h: got %h want %h", op, a, b, {bus.E_HI, bus.E_LO}, {m_hi, m_lo}); else n_pass++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_mult();
    test_multu_stall();
    test_div();
    test_mthi_mtlo();
    test_cancel();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit; holds the architectural HI/LO registers.
- Runs mult/multu/div/divu over multiple cycles, and services mthi/mtlo/mfhi/mflo.
- Its result travels with the instruction into the E/M pipeline register, so it feeds the memory stage as address/store data via forwarding.
- Its stall output is consumed by the hazard unit.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (minimum 1).
- DIV_CYCLES, 10, busy duration of div/divu (minimum 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- E_en  input  1  instruction in E is valid and not being stalled/flushed this cycle; every op is ignored when 0.
- E_mdu_op  input  4  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; codes 9-15 behave as none.
- E_A  input  32  rs operand, already forwarded.
- E_B  input  32  rt operand, already forwarded.
- E_cancel  input  1  abort the in-flight multiply/divide (exception/interrupt flush).
- E_busy  output  1  a multiply/divide is in progress.
- E_mdu_stall  output  1  the hazard unit must hold the instruction in E.
- E_mdu_out  output  32  HI for op 7, LO for op 8, otherwise 0; combinational.
- E_HI  output  32  current HI register.
- E_LO  output  32  current LO register.

Behaviour:
- Reset (asynchronous, active-low): HI=0, LO=0, busy=0, counter=0, result temporaries=0. Outputs follow at once, with no clock edge needed.
- Start condition: E_en=1, op in 1..4, busy=0, E_cancel=0.
  - At that edge the full 64-bit result is computed from E_A/E_B into the temporaries (pending HI / pending LO).
  - busy is set to 1 and the counter loads MULT_CYCLES or DIV_CYCLES.
- While busy:
  - The counter decrements each edge.
  - At the edge where counter==1: HI/LO are loaded from the temporaries, busy goes to 0 and the counter goes to 0.
  - Net effect: busy is high for exactly N cycles after the start edge, and the new HI/LO are visible in the cycle busy first reads 0.
- Arithmetic:
  - mult: signed 32x32 to 64; HI=upper 32 bits, LO=lower 32 bits.
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero; LO=quotient, HI=remainder, remainder takes the sign of the dividend.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned.
  - Divisor 0 (div or divu): busy still runs DIV_CYCLES; HI/LO stay unchanged at completion.
- mthi/mtlo: when E_en=1 and busy=0, HI (or LO) <= E_A at the edge. No busy is generated.
- mfhi/mflo: read combinationally. They return the committed value, never the pending one.
- E_mdu_stall = E_en & (op in 1..8) & (busy | start-cycle pending).
  - In practice: stall=1 whenever busy=1 and the E instruction is any MDU op (1..8).
  - Stall is 0 in the cycle a start is first presented, because that instruction proceeds.
- MDU op presented while busy=1: no effect (the stall holds it). A start is never accepted while busy.
- E_cancel=1 while busy:
  - At the edge, busy goes to 0 and the counter goes to 0.
  - HI/LO keep their pre-operation values and the temporaries are discarded.
  - E_cancel with a start in the same cycle: the start is suppressed.
  - E_cancel with mthi/mtlo in the same cycle: the write is suppressed.
- Non-MDU ops (0, 9-15) never alter any state.
- Reset asserted mid-operation: HI/LO/busy clear immediately, and no commit happens later.

Test Plan:
- Reset release, then mult with E_A=0xFFFFFFFF, E_B=2 and E_en=1 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with E_A=0xFFFFFFFF, E_B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. During cycles 2-5, an mflo held in E -> E_mdu_stall=1 and E_mdu_out shows the old LO.
- div with E_A=0xFFFFFFF9 (-7), E_B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu with E_A=7, E_B=0 -> 10 busy cycles, HI/LO unchanged.
- mthi with E_A=0x12345678, then mtlo with E_A=0x9ABCDEF0, then mfhi and mflo -> E_mdu_out=0x12345678 then 0x9ABCDEF0, with no busy cycles.
- Start mult with 3x4, assert E_cancel in busy cycle 3 -> busy drops at that edge and HI/LO keep their prior values. A following mult with 3x4 -> LO=12, HI=0.
- Pull reset low asynchronously (between clock edges) during a div in progress -> HI=LO=0 and busy=0 immediately, with no later commit. div with 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
